// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
// DECODE_ILLEGAL_EN adds the out_illegal flag.
interface decode_stage_if #(
    parameter int unsigned INSN_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
);
    logic              in_valid;
    logic [INSN_W-1:0] in_insn;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_alu_op;
    logic              out_isSt;
    logic              out_isLd;
    logic              out_isBeq;
    logic              out_isBgt;
    logic              out_isRet;
    logic              out_isImmediate;
    logic              out_isWb;
    logic              out_isUbranch;
    logic              out_isCall;
    logic              out_isMov;
    logic [REG_AW-1:0] out_rd;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [INSN_W-1:0] out_insn;
    logic [CNT_W-1:0]  stall_cnt;
`ifdef DECODE_ILLEGAL_EN
    logic              out_illegal;
`endif

    modport master (
        output in_valid, in_insn, flush, out_ready,
        input  in_ready, out_valid, out_alu_op, out_isSt, out_isLd, out_isBeq,
               out_isBgt, out_isRet, out_isImmediate, out_isWb, out_isUbranch,
               out_isCall, out_isMov, out_rd, out_rs1, out_rs2, out_insn, stall_cnt
`ifdef DECODE_ILLEGAL_EN
        , input out_illegal
`endif
    );

    modport slave (
        input  in_valid, in_insn, flush, out_ready,
        output in_ready, out_valid, out_alu_op, out_isSt, out_isLd, out_isBeq,
               out_isBgt, out_isRet, out_isImmediate, out_isWb, out_isUbranch,
               out_isCall, out_isMov, out_rd, out_rs1, out_rs2, out_insn, stall_cnt
`ifdef DECODE_ILLEGAL_EN
        , output out_illegal
`endif
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode with load-use bubble, flush and saturating stall counter.
// DECODE_ILLEGAL_EN: flag opcodes 10101-11111 on out_illegal instead of decoding them as nop.
module decode_stage #(
    parameter int unsigned INSN_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);
    localparam int unsigned OP_W   = 5;
    localparam int unsigned OP_HI  = INSN_W - 1;
    localparam int unsigned IMM_B  = INSN_W - 6;
    localparam int unsigned RD_HI  = INSN_W - 7;
    localparam int unsigned RS1_HI = RD_HI - REG_AW;
    localparam int unsigned RS2_HI = RS1_HI - REG_AW;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b00010;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b00011;
    localparam logic [OP_W-1:0] OP_MOD  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00110;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00111;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b01000;
    localparam logic [OP_W-1:0] OP_MOV  = 5'b01001;
    localparam logic [OP_W-1:0] OP_LSL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_LSR  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ASR  = 5'b01100;
    localparam logic [OP_W-1:0] OP_LD   = 5'b01110;
    localparam logic [OP_W-1:0] OP_ST   = 5'b01111;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'b10000;
    localparam logic [OP_W-1:0] OP_BGT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_B    = 5'b10010;
    localparam logic [OP_W-1:0] OP_CALL = 5'b10011;
    localparam logic [OP_W-1:0] OP_RET  = 5'b10100;

    typedef struct packed {
        logic is_st;
        logic is_ld;
        logic is_beq;
        logic is_bgt;
        logic is_ret;
        logic is_imm;
        logic is_wb;
        logic is_ubranch;
        logic is_call;
        logic is_mov;
    } ctrl_t;

    logic [OP_W-1:0]   opcode_in;
    logic              imm_in;
    logic [REG_AW-1:0] rd_in, rs1_in, rs2_in, rd_q;
    ctrl_t             dec_ctrl;
    logic              dec_illegal;
    logic              hz, accept;

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [INSN_W-1:0] insn_q, insn_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;

    assign opcode_in = bus.in_insn[OP_HI -: OP_W];
    assign imm_in    = bus.in_insn[IMM_B];
    assign rd_in     = bus.in_insn[RD_HI -: REG_AW];
    assign rs1_in    = bus.in_insn[RS1_HI -: REG_AW];
    assign rs2_in    = bus.in_insn[RS2_HI -: REG_AW];
    assign rd_q      = insn_q[RD_HI -: REG_AW];

    // Opcode to control-flag decode
    always_comb begin
        dec_ctrl        = '0;
        dec_illegal     = 1'b0;
        dec_ctrl.is_imm = imm_in;
        case (opcode_in)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NOT,
            OP_LSL, OP_LSR, OP_ASR: dec_ctrl.is_wb = 1'b1;
            OP_MOV:  begin dec_ctrl.is_mov = 1'b1; dec_ctrl.is_wb = 1'b1; end
            OP_LD:   begin dec_ctrl.is_ld  = 1'b1; dec_ctrl.is_wb = 1'b1; end
            OP_ST:   dec_ctrl.is_st  = 1'b1;
            OP_BEQ:  dec_ctrl.is_beq = 1'b1;
            OP_BGT:  dec_ctrl.is_bgt = 1'b1;
            OP_B:    dec_ctrl.is_ubranch = 1'b1;
            OP_CALL: begin dec_ctrl.is_call = 1'b1; dec_ctrl.is_ubranch = 1'b1; end
            OP_RET:  begin dec_ctrl.is_ret  = 1'b1; dec_ctrl.is_ubranch = 1'b1; end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_EN
        if (opcode_in > OP_RET) begin
            dec_illegal    = 1'b1;
            dec_ctrl.is_wb = 1'b0;
        end
`endif
    end

    // A held load whose destination feeds the incoming instruction forces one bubble
    assign hz = valid_q & ctrl_q.is_ld & bus.in_valid &
                ((rs1_in == rd_q) | ((rs2_in == rd_q) & ~imm_in) |
                 ((opcode_in == OP_ST) & (rd_in == rd_q)));

    assign bus.in_ready = ~bus.flush & ~hz & (~valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // Pipeline register next state; flush wins over consume and accept
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        insn_d    = insn_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else begin
            if (accept) begin
                valid_d   = 1'b1;
                ctrl_d    = dec_ctrl;
                insn_d    = bus.in_insn;
                illegal_d = dec_illegal;
            end else if (bus.out_ready) begin
                valid_d = 1'b0;
            end
            if (hz && bus.out_ready && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            insn_q    <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            insn_q    <= insn_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_alu_op      = insn_q[OP_HI -: OP_W];
    assign bus.out_isSt        = ctrl_q.is_st;
    assign bus.out_isLd        = ctrl_q.is_ld;
    assign bus.out_isBeq       = ctrl_q.is_beq;
    assign bus.out_isBgt       = ctrl_q.is_bgt;
    assign bus.out_isRet       = ctrl_q.is_ret;
    assign bus.out_isImmediate = ctrl_q.is_imm;
    assign bus.out_isWb        = ctrl_q.is_wb;
    assign bus.out_isUbranch   = ctrl_q.is_ubranch;
    assign bus.out_isCall      = ctrl_q.is_call;
    assign bus.out_isMov       = ctrl_q.is_mov;
    assign bus.out_rd          = rd_q;
    assign bus.out_rs1         = insn_q[RS1_HI -: REG_AW];
    assign bus.out_rs2         = insn_q[RS2_HI -: REG_AW];
    assign bus.out_insn        = insn_q;
    assign bus.stall_cnt       = cnt_q;
`ifdef DECODE_ILLEGAL_EN
    assign bus.out_illegal     = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
    localparam logic [9:0] F_ST   = 10'b1000000000;
    localparam logic [9:0] F_LD   = 10'b0100000000;
    localparam logic [9:0] F_BEQ  = 10'b0010000000;
    localparam logic [9:0] F_BGT  = 10'b0001000000;
    localparam logic [9:0] F_RET  = 10'b0000100000;
    localparam logic [9:0] F_IMM  = 10'b0000010000;
    localparam logic [9:0] F_WB   = 10'b0000001000;
    localparam logic [9:0] F_UB   = 10'b0000000100;
    localparam logic [9:0] F_CALL = 10'b0000000010;
    localparam logic [9:0] F_MOV  = 10'b0000000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] exp_cnt = '0;
    logic [31:0] w;

    decode_stage_if #(.INSN_W(32), .REG_AW(4), .CNT_W(16)) bus ();
    decode_stage #(.INSN_W(32), .REG_AW(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic i,
                                       input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [3:0] rs2);
        return {op, i, rd, rs1, rs2, 14'h0155};
    endfunction

    function automatic logic [9:0] flags();
        return {bus.out_isSt, bus.out_isLd, bus.out_isBeq, bus.out_isBgt, bus.out_isRet,
                bus.out_isImmediate, bus.out_isWb, bus.out_isUbranch, bus.out_isCall,
                bus.out_isMov};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_insn = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
        checks++; if (flags() !== 10'd0) begin failures++; $display("FAIL reset_flags got=%b exp=0", flags()); end
        checks++; if (bus.out_insn !== 32'd0) begin failures++; $display("FAIL reset_insn got=%h exp=0", bus.out_insn); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        exp_cnt = '0;
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; w = mk(5'b00000, 1'b0, 4'd1, 4'd2, 4'd3); bus.in_insn = w;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || flags() !== F_WB) begin failures++; $display("FAIL stream_add got=%b/%b exp=1/%b", bus.out_valid, flags(), F_WB); end
        checks++; if (bus.out_rd !== 4'd1 || bus.out_rs1 !== 4'd2 || bus.out_rs2 !== 4'd3 || bus.out_insn !== w) begin failures++; $display("FAIL stream_add_fields got=%h/%h/%h/%h", bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_insn); end
        w = mk(5'b01110, 1'b0, 4'd4, 4'd5, 4'd6); bus.in_insn = w;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || flags() !== (F_LD | F_WB) || bus.out_alu_op !== 5'b01110) begin failures++; $display("FAIL stream_ld got=%b/%b/%b", bus.out_valid, flags(), bus.out_alu_op); end
        bus.in_insn = mk(5'b01111, 1'b0, 4'd7, 4'd8, 4'd9);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_st_ready got=%b exp=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || flags() !== F_ST || bus.out_rd !== 4'd7) begin failures++; $display("FAIL stream_st got=%b/%b/%0d", bus.out_valid, flags(), bus.out_rd); end
        bus.in_insn = mk(5'b10011, 1'b0, 4'd1, 4'd2, 4'd3);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || flags() !== (F_CALL | F_UB)) begin failures++; $display("FAIL stream_call got=%b/%b exp=1/%b", bus.out_valid, flags(), F_CALL | F_UB); end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_load_use();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_insn = mk(5'b01110, 1'b0, 4'd5, 4'd1, 4'd2);
        tick();
        bus.in_insn = mk(5'b00000, 1'b0, 4'd6, 4'd5, 4'd2);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL lu_ready got=%b exp=0", bus.in_ready); end
        tick(); exp_cnt++;
        checks++; if (bus.out_valid !== 1'b0 || bus.stall_cnt !== exp_cnt) begin failures++; $display("FAIL lu_bubble got=%b/%0d exp=0/%0d", bus.out_valid, bus.stall_cnt, exp_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL lu_ready_after got=%b exp=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 4'd6 || flags() !== F_WB) begin failures++; $display("FAIL lu_issue got=%b/%0d/%b", bus.out_valid, bus.out_rd, flags()); end
        // store whose data register is the load destination
        bus.in_insn = mk(5'b01110, 1'b0, 4'd5, 4'd1, 4'd2);
        tick();
        bus.in_insn = mk(5'b01111, 1'b0, 4'd5, 4'd7, 4'd8);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL lu_st_ready got=%b exp=0", bus.in_ready); end
        tick(); exp_cnt++;
        checks++; if (bus.out_valid !== 1'b0 || bus.stall_cnt !== exp_cnt) begin failures++; $display("FAIL lu_st_bubble got=%b/%0d exp=0/%0d", bus.out_valid, bus.stall_cnt, exp_cnt); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || flags() !== F_ST) begin failures++; $display("FAIL lu_st_issue got=%b/%b", bus.out_valid, flags()); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_imm_no_hazard();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_insn = mk(5'b01110, 1'b0, 4'd5, 4'd1, 4'd2);
        tick();
        bus.in_insn = mk(5'b00000, 1'b1, 4'd6, 4'd1, 4'd5);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL imm_ready got=%b exp=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || flags() !== (F_WB | F_IMM) || bus.stall_cnt !== exp_cnt) begin failures++; $display("FAIL imm_issue got=%b/%b/%0d exp cnt=%0d", bus.out_valid, flags(), bus.stall_cnt, exp_cnt); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold_flush();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; w = mk(5'b00001, 1'b0, 4'd3, 4'd1, 4'd2); bus.in_insn = w;
        tick();
        bus.out_ready = 1'b0;
        bus.in_insn = mk(5'b01001, 1'b1, 4'd4, 4'd0, 4'd0);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_insn !== w || bus.out_alu_op !== 5'b00001) begin failures++; $display("FAIL hold_stable got=%b/%h exp=1/%h", bus.out_valid, bus.out_insn, w); end
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_reaccept got=%b exp=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || flags() !== (F_MOV | F_WB | F_IMM)) begin failures++; $display("FAIL flush_mov got=%b/%b", bus.out_valid, flags()); end
        // flush during a load-use hazard: bubble is not counted
        bus.out_ready = 1'b1;
        bus.in_insn = mk(5'b01110, 1'b0, 4'd5, 4'd1, 4'd2);
        tick();
        bus.in_insn = mk(5'b00000, 1'b0, 4'd6, 4'd5, 4'd2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.stall_cnt !== exp_cnt) begin failures++; $display("FAIL flush_cnt got=%b/%0d exp=0/%0d", bus.out_valid, bus.stall_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_opcodes();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_insn = mk(5'b11000, 1'b0, 4'd1, 4'd2, 4'd3);
        tick();
`ifdef DECODE_ILLEGAL_EN
        checks++; if (bus.out_illegal !== 1'b1 || flags() !== 10'd0) begin failures++; $display("FAIL illegal got=%b/%b exp=1/0", bus.out_illegal, flags()); end
`else
        checks++; if (bus.out_valid !== 1'b1 || flags() !== 10'd0 || bus.out_alu_op !== 5'b11000) begin failures++; $display("FAIL undef_as_nop got=%b/%b/%b", bus.out_valid, flags(), bus.out_alu_op); end
`endif
        bus.in_insn = mk(5'b01101, 1'b1, 4'd1, 4'd2, 4'd3);
        tick();
        checks++; if (flags() !== F_IMM) begin failures++; $display("FAIL nop got=%b exp=%b", flags(), F_IMM); end
`ifdef DECODE_ILLEGAL_EN
        checks++; if (bus.out_illegal !== 1'b0) begin failures++; $display("FAIL nop_illegal got=%b exp=0", bus.out_illegal); end
`endif
        bus.in_insn = mk(5'b00101, 1'b0, 4'd1, 4'd2, 4'd3);
        tick();
        checks++; if (flags() !== 10'd0) begin failures++; $display("FAIL cmp got=%b exp=0", flags()); end
        bus.in_insn = mk(5'b10000, 1'b0, 4'd1, 4'd2, 4'd3);
        tick();
        checks++; if (flags() !== F_BEQ) begin failures++; $display("FAIL beq got=%b exp=%b", flags(), F_BEQ); end
        bus.in_insn = mk(5'b10001, 1'b0, 4'd1, 4'd2, 4'd3);
        tick();
        checks++; if (flags() !== F_BGT) begin failures++; $display("FAIL bgt got=%b exp=%b", flags(), F_BGT); end
        bus.in_insn = mk(5'b10010, 1'b0, 4'd1, 4'd2, 4'd3);
        tick();
        checks++; if (flags() !== F_UB) begin failures++; $display("FAIL b got=%b exp=%b", flags(), F_UB); end
        bus.in_insn = mk(5'b10100, 1'b0, 4'd1, 4'd2, 4'd3);
        tick();
        checks++; if (flags() !== (F_RET | F_UB)) begin failures++; $display("FAIL ret got=%b exp=%b", flags(), F_RET | F_UB); end
        bus.in_insn = mk(5'b01100, 1'b0, 4'd1, 4'd2, 4'd3);
        tick();
        checks++; if (flags() !== F_WB || bus.out_valid !== 1'b1) begin failures++; $display("FAIL asr got=%b exp=%b", flags(), F_WB); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_insn = mk(5'b01110, 1'b1, 4'd9, 4'd1, 4'd2);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.stall_cnt !== exp_cnt) begin failures++; $display("FAIL mid_pre got=%b/%0d exp=1/%0d", bus.out_valid, bus.stall_cnt, exp_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || flags() !== 10'd0 || bus.stall_cnt !== 16'd0 || bus.out_insn !== 32'd0) begin failures++; $display("FAIL mid_reset got=%b/%b/%0d/%h", bus.out_valid, flags(), bus.stall_cnt, bus.out_insn); end
        exp_cnt = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_release got=%b/%b exp=1/0", bus.in_ready, bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_imm_no_hazard();
        test_hold_flush();
        test_opcodes();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked successor to the combinational control unit. Decodes one instruction per cycle into the control bundle (ALU op, isSt/isLd/isBeq/isBgt/isRet/isImmediate/isWb/isUbranch/isCall/isMov), holds it in a pipeline register toward execute, and inserts a one-cycle bubble on load-use hazards. Sits between instruction fetch and operand fetch/execute; it provides flush for taken branches and a saturating stall counter.

## Interface
- INSN_W, 32: instruction width, ≥ 6+3*REG_AW.
- REG_AW, 4: register-index width.
- CNT_W, 16: stall counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers instruction.
- in_insn  in  INSN_W  instruction word.
- in_ready  out  1  stage accepts this cycle.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute consumes bundle.
- out_alu_op  out  5  opcode field.
- out_isSt, out_isLd, out_isBeq, out_isBgt, out_isRet, out_isImmediate, out_isWb, out_isUbranch, out_isCall, out_isMov  out  1 each  control flags.
- out_rd, out_rs1, out_rs2  out  REG_AW  register fields.
- out_insn  out  INSN_W  registered instruction word.
- stall_cnt  out  CNT_W  saturating count of hazard-bubble cycles.

## Operation
- Fields: opcode = in_insn[INSN_W-1 -: 5]; I = in_insn[INSN_W-6]; rd, rs1, rs2 follow consecutively below I, REG_AW bits each.
- isImmediate = I for every opcode.
- Decode: 00000 add, 00001 sub, 00010 mul, 00011 div, 00100 mod, 00110 and, 00111 or, 01000 not, 01010 lsl, 01011 lsr, 01100 asr → isWb. 00101 cmp → no flags. 01001 mov → isMov+isWb. 01110 ld → isLd+isWb. 01111 st → isSt. 10000 beq → isBeq. 10001 bgt → isBgt. 10010 b → isUbranch. 10011 call → isCall+isUbranch. 10100 ret → isRet+isUbranch. 01101 nop and 10101–11111 → no flags.
- Hazard: hz = out_valid & out_isLd & in_valid & (rs1_in==out_rd | (rs2_in==out_rd & !I_in) | (opcode_in==st & rd_in==out_rd)).
- in_ready = !flush & !hz & (!out_valid | out_ready).
- Accept (in_valid & in_ready): output register loads decoded bundle, out_valid←1.
- Consume without accept: out_valid←0 (bubble when caused by hz).
- Held bundle and out_valid stable while out_valid & !out_ready.
- stall_cnt increments each cycle hz=1 and out_ready=1; saturates at all-ones.

## Timing
- Latency: 1 cycle accept→out_valid.
- Throughput: 1/cycle without hazards; load-use costs exactly one bubble.
- flush: priority over everything; next cycle out_valid=0, incoming dropped, in_ready=0 during flush cycle; stall_cnt unchanged.
- Simultaneous consume+accept: bundle replaced, out_valid stays 1.
- Reset (async, any time incl. mid-stall): out_valid=0, all out_* flags/fields=0, out_insn=0, stall_cnt=0; in_ready=1 after release.

## Configuration
- DECODE_ILLEGAL_EN defined: opcodes 10101–11111 are flagged by extra output out_illegal (1 bit, registered with bundle, reset 0), isWb forced 0. Undefined: port absent, those opcodes decode as nop.

## Test plan
- Reset mid-stream: rst pulse while out_valid=1 → out_valid=0, stall_cnt=0, all flags 0 immediately.
- Stream add r1,r2,r3 (00000), ld (01110), st (01111), call (10011) with out_ready=1 → one bundle/cycle; flags isWb; isLd+isWb; isSt; isCall+isUbranch.
- ld r5 then add r6,r5,r2 → in_ready=0 one cycle, one bubble (out_valid=0), add issues next; stall_cnt=1.
- ld r5 then add r6,r1,#imm with rs2 field=5, I=1 → no bubble, stall_cnt=0.
- out_ready=0 for 3 cycles → bundle held stable, in_ready=0; flush in cycle 2 → out_valid=0 next cycle.
- DECODE_ILLEGAL_EN on: opcode 11000 → out_illegal=1, all other flags 0; off: decoded as nop.
